// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instr_mem and the IF/ID stage.
// Owns the fetch PC, issues sequential requests to a 1-cycle-latency synchronous
// ROM, and buffers up to DEPTH returned words so decode stalls never drop or
// refetch instructions. A redirect flushes the queue and kills any in-flight fetch.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   redirect, redirect_pc     flush queue and restart fetch at redirect_pc
//   imem_req, imem_addr       fetch request / registered fetch PC
//   imem_data                 ROM word, valid the cycle after imem_req
//   deq_ready                 consumer accepts head entry
//   deq_valid, deq_instr,
//   deq_pc                    head entry (read combinationally from the queue)
//   count, full, empty        occupancy status
//
// Optional feature (macro FETCHQ_BYPASS_EN): a response arriving while the queue
// is empty is presented on deq_* in the same cycle and is not stored if consumed.
module fetch_queue #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [DATA_W-1:0]       imem_data,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output logic [DATA_W-1:0]       deq_instr,
  output logic [ADDR_W-1:0]       deq_pc,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_RST_WAIT, ST_RUN} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic               inflight_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               full_q;
  logic               empty_q;
  logic [DATA_W-1:0]  instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];

  logic               enq;
  logic               deq;
  logic               wr_en;
  logic               rd_adv;
  logic [CNT_W:0]     credit;

  // Credit check counts the in-flight word; a same-cycle dequeue earns no credit.
  always_comb begin
    credit   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    imem_req = (state_q == ST_RUN) && !redirect && (credit < (CNT_W + 1)'(DEPTH));
    enq      = inflight_q && !redirect;
  end

`ifdef FETCHQ_BYPASS_EN
  logic bypass;

  // Empty queue: the arriving word is the head; it is stored only if not taken now.
  always_comb begin
    bypass    = enq && (count_q == '0);
    deq_valid = bypass || (count_q != '0);
    deq_instr = bypass ? imem_data     : instr_q[rd_ptr_q];
    deq_pc    = bypass ? inflight_pc_q : pc_q[rd_ptr_q];
    deq       = deq_valid && deq_ready;
    wr_en     = enq && !(bypass && deq_ready);
    rd_adv    = deq && !bypass;
  end
`else
  // Every response goes through the queue; head read straight from storage.
  always_comb begin
    deq_valid = (count_q != '0);
    deq_instr = instr_q[rd_ptr_q];
    deq_pc    = pc_q[rd_ptr_q];
    deq       = deq_valid && deq_ready;
    wr_en     = enq;
    rd_adv    = deq;
  end
`endif

  // Occupancy next value; redirect clears regardless of enq/deq.
  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
    end
  end

  // All sequential state: FSM, fetch PC, in-flight tracking, queue storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST_WAIT;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q <= ST_RUN;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        inflight_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        inflight_q <= imem_req;
        if (imem_req) begin
          fetch_pc_q    <= fetch_pc_q + ADDR_W'(PC_STEP);
          inflight_pc_q <= fetch_pc_q;
        end
        if (wr_en) begin
          instr_q[wr_ptr_q] <= imem_data;
          pc_q[wr_ptr_q]    <= inflight_pc_q;
          wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        end
        if (rd_adv) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a cycle model and a
// scoreboard of expected dequeue PCs (pushed on each expected request).
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  fetch_queue dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_instr   (deq_instr),
    .deq_pc      (deq_pc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents distinct from the address so data/pc swaps are visible.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  always @(posedge clock) imem_data <= rom(imem_addr);

  int          checks = 0;
  int          errors = 0;
  int          n_obs_req = 0;
  logic [31:0] sb[$];
  logic        m_run;
  logic        m_inflight;
  int          m_count;
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_inflight = 1'b0; m_count = 0; m_pc = 32'h0;
    sb.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
    logic        exp_req;
    logic        exp_valid;
    logic        byp;
    logic [31:0] pc;
    deq_ready = rdy; redirect = rdr; redirect_pc = rpc;
    #1;
    exp_req = m_run && !rdr && ((m_count + int'(m_inflight)) < DEPTH);
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (m_count == 0) && m_inflight && !rdr;
`endif
    exp_valid = (m_count != 0) || byp;
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_count == DEPTH));
    chk("empty", 64'(empty), 64'(m_count == 0));
    if (imem_req) n_obs_req++;
    if (exp_valid && rdy) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb_underflow: observed deq_pc %0h expected no dequeue", deq_pc);
      end else begin
        pc = sb.pop_front();
        chk("deq_pc", 64'(deq_pc), 64'(pc));
        chk("deq_instr", 64'(deq_instr), 64'(rom(pc)));
      end
    end
    if (exp_req) sb.push_back(m_pc);
    if (rdr) begin
      m_count = 0; m_inflight = 1'b0; m_pc = rpc;
      sb.delete();
    end else begin
      m_count = m_count + int'(m_inflight) - int'(exp_valid && rdy);
      m_inflight = exp_req;
      if (exp_req) m_pc = m_pc + 32'd4;
    end
    m_run = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    deq_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_deq_valid", 64'(deq_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    reset_n = 1'b1;

    // Streaming with decode always ready.
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Restart at 0, stall 10 cycles: exactly DEPTH requests, then full.
    cycle(1'b0, 1'b1, 32'h0);
    n_obs_req = 0;
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    chk("stall_reqs", 64'(n_obs_req), 64'(DEPTH));
    chk("stall_full", 64'(full), 64'(1));

    // Full queue holding 0..12, redirect to 0x100, then drain.
    cycle(1'b0, 1'b1, 32'h100);
    chk("redir_count", 64'(count), 64'(0));
    chk("redir_empty", 64'(empty), 64'(1));
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Redirect coincident with response and dequeue.
    cycle(1'b1, 1'b1, 32'h200);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Back-to-back redirects: last wins.
    cycle(1'b1, 1'b1, 32'h300);
    cycle(1'b1, 1'b1, 32'h400);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Fetch PC wrap across 2^32.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", 64'(imem_addr), 64'h0);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);

    // Random ready pattern with occasional redirects.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0)
        cycle(1'($urandom_range(0, 1)), 1'b1, $urandom() & 32'hFFFF_FFFC);
      else
        cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    // Fill to count 3, then assert reset asynchronously mid-cycle.
    cycle(1'b0, 1'b1, 32'h500);
    for (int i = 0; i < 10 && m_count != 3; i++) cycle(1'b0, 1'b0, 32'h0);
    if (m_count != 3) begin
      checks++; errors++;
      $error("FAIL fill3: observed model count %0d expected 3", m_count);
    end
    chk("pre_rst_count", 64'(count), 64'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'(0));
    chk("async_empty", 64'(empty), 64'(1));
    chk("async_full", 64'(full), 64'(0));
    chk("async_deq_valid", 64'(deq_valid), 64'(0));
    chk("async_imem_req", 64'(imem_req), 64'(0));
    chk("async_imem_addr", 64'(imem_addr), 64'(0));
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
